// File: rtl/ps2_scan_rx_if.sv
// PS/2 receiver bus: the keyboard lines coming in, and the scan-code history with its status going out.
// The receiver takes the master view and the keyboard/consumer side takes the slave view.
interface ps2_scan_rx_if;
    logic        PS2C;
    logic        PS2D;
    logic [15:0] KBBuffer;
    logic        New_Key;
    logic        Frame_Err;
    logic        Rx_Busy;

    modport master (
        input  PS2C,
        input  PS2D,
        output KBBuffer,
        output New_Key,
        output Frame_Err,
        output Rx_Busy
    );

    modport slave (
        output PS2C,
        output PS2D,
        input  KBBuffer,
        input  New_Key,
        input  Frame_Err,
        input  Rx_Busy
    );
endinterface

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: conditions PS2C/PS2D, deserializes 11-bit frames and keeps the
// last two good scan bytes as {previous, latest}, with one-cycle New_Key / Frame_Err pulses.
module ps2_scan_rx #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic          CLK,
    input  logic          RESET,
    ps2_scan_rx_if.master bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic                  c_meta, c_sync;
    logic                  d_meta, d_sync;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  clk_filt, clk_filt_q;
    logic                  fall;
    logic                  timeout;
    logic [CNT_W-1:0]      to_cnt;

    state_t      state, state_n;
    logic [2:0]  bitcnt, bitcnt_n;
    logic [7:0]  shreg, shreg_n;
    logic        par_bit, par_n;
    logic [15:0] kb_buf, kb_n;
    logic        new_key, new_key_n;
    logic        frame_err, frame_err_n;

    // Both lines idle high, so the synchronizers and filter come out of reset at 1.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            c_meta     <= 1'b1;
            c_sync     <= 1'b1;
            d_meta     <= 1'b1;
            d_sync     <= 1'b1;
            filt_sr    <= '1;
            clk_filt   <= 1'b1;
            clk_filt_q <= 1'b1;
        end else begin
            c_meta     <= bus.PS2C;
            c_sync     <= c_meta;
            d_meta     <= bus.PS2D;
            d_sync     <= d_meta;
            filt_sr    <= {filt_sr[FILTER_LEN-2:0], c_sync};
            clk_filt_q <= clk_filt;
            if (filt_sr == '0)
                clk_filt <= 1'b0;
            else if (filt_sr == '1)
                clk_filt <= 1'b1;
        end
    end

    assign fall    = clk_filt_q & ~clk_filt;
    assign timeout = (state != IDLE) && (to_cnt == TO_MAX);

    // Idle-gap watchdog: any fall restarts it, and it is parked at zero while IDLE.
    always_ff @(posedge CLK) begin
        if (RESET || state == IDLE || timeout || fall)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            kb_buf    <= '0;
            new_key   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            bitcnt    <= bitcnt_n;
            shreg     <= shreg_n;
            par_bit   <= par_n;
            kb_buf    <= kb_n;
            new_key   <= new_key_n;
            frame_err <= frame_err_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n     = state;
        bitcnt_n    = bitcnt;
        shreg_n     = shreg;
        par_n       = par_bit;
        kb_n        = kb_buf;
        new_key_n   = 1'b0;
        frame_err_n = 1'b0;

        if (timeout) begin
            // A stalled frame is abandoned quietly; an edge arriving now is ignored.
            state_n = IDLE;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!d_sync) begin
                        state_n  = DATA;
                        bitcnt_n = '0;
                    end
                end
                DATA: begin
                    shreg_n  = {d_sync, shreg[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7)
                        state_n = PARITY;
                end
                PARITY: begin
                    par_n   = d_sync;
                    state_n = STOP;
                end
                STOP: begin
                    if (d_sync && ((^shreg) ^ par_bit)) begin
                        kb_n      = {kb_buf[7:0], shreg};
                        new_key_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.KBBuffer  = kb_buf;
    assign bus.New_Key   = new_key;
    assign bus.Frame_Err = frame_err;
    assign bus.Rx_Busy   = (state != IDLE);

    a_pulse_exclusive: assert property (@(posedge CLK) disable iff (RESET) !(new_key && frame_err));

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Self-checking bench for ps2_scan_rx: directed make/break, error, glitch, timeout and reset
// scenarios plus randomized frames scored against a queue of accepted scan bytes.
module tb_ps2_scan_rx;

    localparam int unsigned FILTER_LEN  = 8;
    localparam int unsigned TIMEOUT_CYC = 400;
    // Drive-to-pulse delay: 2 sync flops + FILTER_LEN filter stages + filtered-clk flop + output flop.
    localparam int EXP_LAT = FILTER_LEN + 4;

    logic CLK;
    logic RESET;
    ps2_scan_rx_if bus();

    ps2_scan_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests_run    = 0;
    int tests_failed = 0;

    int          cyc       = 0;
    logic        rst_edge  = 1'b1;
    int          nk_cnt    = 0;
    int          fe_cnt    = 0;
    int          pulse_cyc = 0;
    int          both_cnt  = 0;
    int          stray_cnt = 0;
    logic [15:0] kb_prev   = '0;
    int          stop_cyc  = 0;

    logic [7:0] good_q[$];

    always @(posedge CLK) begin
        cyc++;
        rst_edge = RESET;
    end

    always @(negedge CLK) begin
        if (bus.New_Key) begin
            nk_cnt++;
            pulse_cyc = cyc;
        end
        if (bus.Frame_Err) begin
            fe_cnt++;
            pulse_cyc = cyc;
        end
        if (bus.New_Key && bus.Frame_Err)
            both_cnt++;
        if (!rst_edge && bus.KBBuffer !== kb_prev && !bus.New_Key)
            stray_cnt++;
        kb_prev = bus.KBBuffer;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1);
    end

    function automatic logic [15:0] exp_kb();
        logic [7:0] lo, hi;
        lo = (good_q.size() > 0) ? good_q[good_q.size()-1] : 8'h00;
        hi = (good_q.size() > 1) ? good_q[good_q.size()-2] : 8'h00;
        return {hi, lo};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
        good_q.delete();
    endtask

    // One PS/2 bit: data changes while the clock is high, then a 20-cycle low phase.
    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.PS2D = frame[i];
            tick(10);
            bus.PS2C = 1'b0;
            if (i == 10)
                stop_cyc = cyc;
            tick(20);
            bus.PS2C = 1'b1;
            tick(10);
        end
        bus.PS2D = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              output int dnk, output int dfe, output int lat);
        int nk0, fe0;
        nk0 = nk_cnt;
        fe0 = fe_cnt;
        send_bits(make_frame(b, bad_par, bad_stop), 11);
        tick(4);
        dnk = nk_cnt - nk0;
        dfe = fe_cnt - fe0;
        lat = pulse_cyc - stop_cyc;
    endtask

    task automatic test_reset();
        bus.PS2C = 1'b1;
        bus.PS2D = 1'b1;
        RESET    = 1'b1;
        tick(3);
        RESET = 1'b0;
        good_q.delete();
        tick(1);
        tests_run++;
        if (bus.KBBuffer !== 16'h0000 || bus.New_Key !== 1'b0 || bus.Frame_Err !== 1'b0 || bus.Rx_Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: kb=%h nk=%b fe=%b busy=%b, want kb=0000 nk=0 fe=0 busy=0",
                     bus.KBBuffer, bus.New_Key, bus.Frame_Err, bus.Rx_Busy);
        end
    endtask

    task automatic test_make_break();
        logic [7:0]  codes[3] = '{8'h1C, 8'hF0, 8'h1C};
        logic [15:0] want[3]  = '{16'h001C, 16'h1CF0, 16'hF01C};
        int dnk, dfe, lat;
        for (int i = 0; i < 3; i++) begin
            send_frame(codes[i], 1'b0, 1'b0, dnk, dfe, lat);
            good_q.push_back(codes[i]);
            tests_run++;
            if (bus.KBBuffer !== want[i] || dnk !== 1 || dfe !== 0) begin
                tests_failed++;
                $display("FAIL make_break[%0d]: kb=%h nk=%0d fe=%0d, want kb=%h nk=1 fe=0",
                         i, bus.KBBuffer, dnk, dfe, want[i]);
            end
            tests_run++;
            if (lat !== EXP_LAT) begin
                tests_failed++;
                $display("FAIL make_break_latency[%0d]: got %0d cycles, want %0d", i, lat, EXP_LAT);
            end
        end
    endtask

    task automatic test_parity_err();
        int dnk, dfe, lat;
        send_frame(8'h45, 1'b1, 1'b0, dnk, dfe, lat);
        tests_run++;
        if (bus.KBBuffer !== 16'hF01C || dnk !== 0 || dfe !== 1) begin
            tests_failed++;
            $display("FAIL parity_err: kb=%h nk=%0d fe=%0d, want kb=F01C nk=0 fe=1", bus.KBBuffer, dnk, dfe);
        end
        tests_run++;
        if (lat !== EXP_LAT) begin
            tests_failed++;
            $display("FAIL parity_err_latency: got %0d cycles, want %0d", lat, EXP_LAT);
        end
    endtask

    task automatic test_glitch();
        int busy_hits = 0;
        int nk0, fe0;
        int widths[2] = '{3, FILTER_LEN - 1};
        nk0 = nk_cnt;
        fe0 = fe_cnt;
        bus.PS2D = 1'b0;
        for (int g = 0; g < 2; g++) begin
            tick(5);
            bus.PS2C = 1'b0;
            tick(widths[g]);
            bus.PS2C = 1'b1;
            for (int c = 0; c < 30; c++) begin
                tick(1);
                if (bus.Rx_Busy !== 1'b0)
                    busy_hits++;
            end
        end
        // A real clock pulse with data high is a spurious edge and must not start a frame.
        bus.PS2D = 1'b1;
        tick(5);
        bus.PS2C = 1'b0;
        tick(20);
        bus.PS2C = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick(1);
            if (bus.Rx_Busy !== 1'b0)
                busy_hits++;
        end
        tests_run++;
        if (busy_hits !== 0 || nk_cnt !== nk0 || fe_cnt !== fe0) begin
            tests_failed++;
            $display("FAIL glitch: busy_cycles=%0d nk=%0d fe=%0d, want 0 0 0", busy_hits, nk_cnt - nk0, fe_cnt - fe0);
        end
    endtask

    task automatic test_timeout();
        logic [15:0] kb0;
        int nk0, fe0, dnk, dfe, lat;
        kb0 = bus.KBBuffer;
        nk0 = nk_cnt;
        fe0 = fe_cnt;
        send_bits(make_frame(8'h33, 1'b0, 1'b0), 4);
        tick(TIMEOUT_CYC - 50);
        tests_run++;
        if (bus.Rx_Busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_not_early: busy=%b, want 1", bus.Rx_Busy);
        end
        tick(100);
        tests_run++;
        if (bus.Rx_Busy !== 1'b0 || nk_cnt !== nk0 || fe_cnt !== fe0 || bus.KBBuffer !== kb0) begin
            tests_failed++;
            $display("FAIL timeout_abort: busy=%b nk=%0d fe=%0d kb=%h, want busy=0 nk=0 fe=0 kb=%h",
                     bus.Rx_Busy, nk_cnt - nk0, fe_cnt - fe0, bus.KBBuffer, kb0);
        end
        send_frame(8'h5A, 1'b0, 1'b0, dnk, dfe, lat);
        good_q.push_back(8'h5A);
        tests_run++;
        if (bus.KBBuffer !== exp_kb() || bus.KBBuffer[7:0] !== 8'h5A || dnk !== 1 || dfe !== 0) begin
            tests_failed++;
            $display("FAIL timeout_recover: kb=%h nk=%0d fe=%0d, want kb=%h nk=1 fe=0", bus.KBBuffer, dnk, dfe, exp_kb());
        end
    endtask

    task automatic test_bad_stop();
        logic [15:0] kb0;
        int dnk, dfe, lat;
        kb0 = bus.KBBuffer;
        send_frame(8'h29, 1'b0, 1'b1, dnk, dfe, lat);
        tests_run++;
        if (bus.KBBuffer !== kb0 || dnk !== 0 || dfe !== 1) begin
            tests_failed++;
            $display("FAIL bad_stop: kb=%h nk=%0d fe=%0d, want kb=%h nk=0 fe=1", bus.KBBuffer, dnk, dfe, kb0);
        end
        send_frame(8'h66, 1'b0, 1'b0, dnk, dfe, lat);
        good_q.push_back(8'h66);
        tests_run++;
        if (bus.KBBuffer !== exp_kb() || bus.KBBuffer[7:0] !== 8'h66 || dnk !== 1 || dfe !== 0) begin
            tests_failed++;
            $display("FAIL bad_stop_recover: kb=%h nk=%0d fe=%0d, want kb=%h nk=1 fe=0", bus.KBBuffer, dnk, dfe, exp_kb());
        end
    endtask

    task automatic test_reset_mid_frame();
        int dnk, dfe, lat;
        send_bits(make_frame(8'h16, 1'b0, 1'b0), 5);
        tests_run++;
        if (bus.Rx_Busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_frame_busy: busy=%b, want 1", bus.Rx_Busy);
        end
        apply_reset();
        tests_run++;
        if (bus.KBBuffer !== 16'h0000 || bus.New_Key !== 1'b0 || bus.Frame_Err !== 1'b0 || bus.Rx_Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_frame_reset: kb=%h nk=%b fe=%b busy=%b, want all 0",
                     bus.KBBuffer, bus.New_Key, bus.Frame_Err, bus.Rx_Busy);
        end
        tick(20);
        send_frame(8'h16, 1'b0, 1'b0, dnk, dfe, lat);
        good_q.push_back(8'h16);
        tests_run++;
        if (bus.KBBuffer !== 16'h0016 || dnk !== 1 || dfe !== 0) begin
            tests_failed++;
            $display("FAIL reset_recover: kb=%h nk=%0d fe=%0d, want kb=0016 nk=1 fe=0", bus.KBBuffer, dnk, dfe);
        end
    endtask

    task automatic test_random_frames();
        int dnk, dfe, lat, err_kind;
        logic [7:0] b;
        bit bad_par, bad_stop, good;
        for (int n = 0; n < 30; n++) begin
            b        = 8'($urandom);
            err_kind = int'($urandom_range(0, 9));
            bad_par  = (err_kind == 7 || err_kind == 9);
            bad_stop = (err_kind == 8 || err_kind == 9);
            good     = !bad_par && !bad_stop;
            send_frame(b, bad_par, bad_stop, dnk, dfe, lat);
            if (good)
                good_q.push_back(b);
            tests_run++;
            if (dnk !== int'(good) || dfe !== int'(!good)) begin
                tests_failed++;
                $display("FAIL random_pulses[%0d] byte=%h par_err=%b stop_err=%b: nk=%0d fe=%0d, want nk=%0d fe=%0d",
                         n, b, bad_par, bad_stop, dnk, dfe, int'(good), int'(!good));
            end
            tests_run++;
            if (bus.KBBuffer !== exp_kb()) begin
                tests_failed++;
                $display("FAIL random_kb[%0d] byte=%h: kb=%h, want %h", n, b, bus.KBBuffer, exp_kb());
            end
            tests_run++;
            if (lat !== EXP_LAT) begin
                tests_failed++;
                $display("FAIL random_latency[%0d]: got %0d cycles, want %0d", n, lat, EXP_LAT);
            end
            tick(int'($urandom_range(0, 40)));
        end
    endtask

    task automatic test_invariants();
        tests_run++;
        if (both_cnt !== 0) begin
            tests_failed++;
            $display("FAIL pulse_overlap: %0d cycles with New_Key and Frame_Err together, want 0", both_cnt);
        end
        tests_run++;
        if (stray_cnt !== 0) begin
            tests_failed++;
            $display("FAIL kb_stray_update: %0d KBBuffer changes without New_Key, want 0", stray_cnt);
        end
    endtask

    initial begin
        RESET    = 1'b1;
        bus.PS2C = 1'b1;
        bus.PS2D = 1'b1;
        @(posedge CLK);
        #1;
        test_reset();
        test_make_break();
        test_parity_err();
        test_glitch();
        test_timeout();
        test_bad_stop();
        test_reset_mid_frame();
        test_random_frames();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
